// File: rtl/sim_bus_pkg.sv
// Shared definitions for the simulation debug-bus slaves: register offsets,
// response codes, UART serializer state encoding and STATUS word layout.
package sim_bus_pkg;

  localparam logic [3:0] TXDATA = 4'h0;
  localparam logic [3:0] STATUS = 4'h4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 8;

  // The debug bus presents register words with reversed byte order.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/sim_sync_fifo.sv
// Single-clock circular FIFO with one extra pointer bit to tell full from empty.
// Read data is the head entry (first-word fall-through).
module sim_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/sim_uart_tx_slave.sv
// Debug-bus UART transmit slave: TXDATA writes queue characters, STATUS reads
// report progress, uart_all_done flags that the line has drained.
// Define SIM_UART_PRINT_EN to also echo each popped character to the console.
module sim_uart_tx_slave
  import sim_bus_pkg::*;
#(
  parameter int          CLKS_PER_BIT        = 4,
  parameter int          FIFO_DEPTH          = 16,
  parameter logic [27:0] BASE_ADDR_HI        = 28'he000_ffe,
  parameter bit          ASSUMED_TRANSACTION = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  bus_burstcount,
  input  logic [31:0] bus_writedata,
  input  logic [31:0] bus_address,
  input  logic        bus_write,
  input  logic        bus_read,
  input  logic [3:0]  bus_byteenable,
  output logic        s_waitrequest,
  output logic [31:0] s_readdata,
  output logic        s_readdatavalid,
  output logic        s_writeresponsevalid,
  output logic [1:0]  s_response,
  output logic        uart_tx_o,
  output logic        uart_all_done
);

  localparam int                AW       = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [3:0]  offset;
  logic        sel, wr_acc, rd_acc, burst_err, req_err, push;
  logic        fifo_full, fifo_empty, pop;
  logic [7:0]  fifo_rdata;
  logic [AW:0] fifo_count;
  logic [31:0] status_w;
  logic        unused_bits;

  logic        rdv_q, rdv_d, wrv_q, wrv_d;
  logic [1:0]  resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             bit_done;

  assign unused_bits = ^{bus_writedata[23:0], bus_byteenable[2:0]};

  // Bus decode and accept
  assign offset        = bus_address[3:0];
  assign sel           = ASSUMED_TRANSACTION || (bus_address[31:4] == BASE_ADDR_HI);
  assign s_waitrequest = sel & bus_write & (offset == TXDATA) & fifo_full;
  assign wr_acc        = sel & bus_write & ~s_waitrequest;
  assign rd_acc        = sel & bus_read & ~bus_write;
  assign burst_err     = (bus_burstcount != 5'd1);
  assign req_err       = burst_err | (bus_read & bus_write);
  assign push          = wr_acc & (offset == TXDATA) & bus_byteenable[3] & ~burst_err;

  sim_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i (bus_writedata[31:24]),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    status_w                            = '0;
    status_w[STAT_BUSY]                 = (state_q != IDLE);
    status_w[STAT_FULL]                 = fifo_full;
    status_w[STAT_EMPTY]                = fifo_empty;
    status_w[STAT_COUNT_LSB +: 8]       = 8'(fifo_count);
  end

  always_comb begin
    wrv_d   = wr_acc;
    rdv_d   = rd_acc;
    resp_d  = ((wr_acc | rd_acc) & req_err) ? RESP_SLVERR : RESP_OKAY;
    rdata_d = rdata_q;
    if (rd_acc) rdata_d = (offset == STATUS) ? byte_swap32(status_w) : '0;
  end

  // Response stage: one cycle after accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdv_q   <= 1'b0;
      wrv_q   <= 1'b0;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
    end else begin
      rdv_q   <= rdv_d;
      wrv_q   <= wrv_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign bit_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA:    if (bit_done && bit_q == 3'd7) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop     = 1'b0;
    tx_d    = 1'b1;
    cnt_d   = bit_done ? '0 : cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = fifo_empty & (state_q == IDLE);
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
        end
      end
      START: tx_d = 1'b0;
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Line stage: serial output and drain flag are registered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      bit_q  <= '0;
      tx_q   <= 1'b1;
      done_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      tx_q   <= tx_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

`ifdef SIM_UART_PRINT_EN
  always @(posedge clk_i) begin
    if (!rst_i && pop) begin
      $write("%c", fifo_rdata);
    end
  end
`else
  // Characters are observable only on uart_tx_o in this build.
`endif

  assign s_readdata           = rdata_q;
  assign s_readdatavalid      = rdv_q;
  assign s_writeresponsevalid = wrv_q;
  assign s_response           = resp_q;
  assign uart_tx_o            = tx_q;
  assign uart_all_done        = done_q;

endmodule

// File: tb/tb_sim_uart_tx_slave.sv
// Self-checking bench for sim_uart_tx_slave: a line receiver decodes frames
// into a queue that is checked against bytes recorded when writes are accepted.
module tb_sim_uart_tx_slave;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] A_TX  = 32'hE000_FFE0;
  localparam logic [31:0] A_ST  = 32'hE000_FFE4;
  localparam logic [31:0] A_OTH = 32'hE000_FFE8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  bus_burstcount;
  logic [31:0] bus_writedata, bus_address;
  logic        bus_write, bus_read;
  logic [3:0]  bus_byteenable;
  logic        s_waitrequest, s_readdatavalid, s_writeresponsevalid;
  logic [31:0] s_readdata;
  logic [1:0]  s_response;
  logic        uart_tx_o, uart_all_done;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  bit         mon_active = 1'b0;
  logic       mon_prev = 1'b1;
  int         mon_t = 0;
  int         mon_ferr = 0;
  logic [7:0] mon_byte;

  always #5 clk = ~clk;

  sim_uart_tx_slave #(
    .CLKS_PER_BIT        (CPB),
    .FIFO_DEPTH          (DEPTH),
    .BASE_ADDR_HI        (28'he000_ffe),
    .ASSUMED_TRANSACTION (1'b0)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst_i),
    .bus_burstcount       (bus_burstcount),
    .bus_writedata        (bus_writedata),
    .bus_address          (bus_address),
    .bus_write            (bus_write),
    .bus_read             (bus_read),
    .bus_byteenable       (bus_byteenable),
    .s_waitrequest        (s_waitrequest),
    .s_readdata           (s_readdata),
    .s_readdatavalid      (s_readdatavalid),
    .s_writeresponsevalid (s_writeresponsevalid),
    .s_response           (s_response),
    .uart_tx_o            (uart_tx_o),
    .uart_all_done        (uart_all_done)
  );

  // Line receiver: start bit seen at t=0, data bits sampled mid-bit, stop at t=37.
  always @(negedge clk) begin
    if (rst_i === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (mon_prev === 1'b1 && uart_tx_o === 1'b0) begin
        mon_active = 1'b1;
        mon_t = 0;
      end
    end else begin
      mon_t++;
      if (mon_t >= 5 && mon_t <= 33 && ((mon_t - 5) % 4) == 0)
        mon_byte[3'((mon_t - 5) / 4)] = uart_tx_o;
      if (mon_t == 37) begin
        if (uart_tx_o !== 1'b1) mon_ferr++;
        rx_q.push_back(mon_byte);
        mon_active = 1'b0;
      end
    end
    mon_prev = uart_tx_o;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus_write = 1'b0; bus_read = 1'b0; bus_address = '0;
    bus_writedata = '0; bus_byteenable = '0; bus_burstcount = 5'd1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input logic [4:0] bc, input bit rd_too,
                          output logic wrv, output logic rdv, output logic [1:0] resp);
    int stall = 0;
    bus_address = addr; bus_writedata = data; bus_byteenable = be;
    bus_burstcount = bc; bus_write = 1'b1; bus_read = rd_too;
    #1;
    while (s_waitrequest === 1'b1 && stall < 1000) begin @(negedge clk); stall++; end
    @(posedge clk); #1;
    bus_write = 1'b0; bus_read = 1'b0; bus_burstcount = 5'd1;
    @(negedge clk);
    wrv = s_writeresponsevalid; rdv = s_readdatavalid; resp = s_response;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [4:0] bc,
                         output logic rdv_early, output logic rdv,
                         output logic [31:0] data, output logic [1:0] resp);
    bus_address = addr; bus_burstcount = bc; bus_read = 1'b1;
    #1;
    rdv_early = s_readdatavalid;
    @(posedge clk); #1;
    bus_read = 1'b0; bus_burstcount = 5'd1;
    @(negedge clk);
    rdv = s_readdatavalid; data = s_readdata; resp = s_response;
  endtask

  // Back-to-back TXDATA writes, one per cycle unless stalled.
  task automatic write_stream(input int n, input logic [7:0] first, input bit track,
                              output int total_stall, output int last_stall);
    total_stall = 0; last_stall = 0;
    for (int i = 0; i < n; i++) begin
      int stall = 0;
      bus_address = A_TX; bus_writedata = {first + 8'(i), 24'h00A5C3};
      bus_byteenable = 4'hF; bus_burstcount = 5'd1; bus_write = 1'b1;
      #1;
      while (s_waitrequest === 1'b1 && stall < 2000) begin @(negedge clk); stall++; end
      @(posedge clk);
      if (track) exp_q.push_back(first + 8'(i));
      total_stall += stall; last_stall = stall;
      @(negedge clk);
    end
    bus_write = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin @(negedge clk); c++; end
    ok = (rx_q.size() >= n);
  endtask

  task automatic drain_and_compare(input string tag, input int budget);
    bit ok;
    int n = exp_q.size();
    wait_rx(n, budget, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_rx_count: got %0d bytes want %0d", tag, rx_q.size(), n);
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      logic [7:0] e, r;
      e = exp_q.pop_front(); r = rx_q.pop_front();
      n_cmp++;
      if (r !== e) begin n_fail++; $display("FAIL %s_byte: got %h want %h", tag, r, e); end
    end
    exp_q.delete(); rx_q.delete();
    n_cmp++;
    if (mon_ferr != 0) begin n_fail++; $display("FAIL %s_stop_bit: got %0d framing errors want 0", tag, mon_ferr); end
    mon_ferr = 0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({uart_tx_o, uart_all_done} !== 2'b11) begin
      n_fail++; $display("FAIL reset_line: got tx/done %b want 11", {uart_tx_o, uart_all_done});
    end
    n_cmp++;
    if ({s_readdatavalid, s_writeresponsevalid, s_response} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_resp: got %b want 0000",
                         {s_readdatavalid, s_writeresponsevalid, s_response});
    end
    n_cmp++;
    if (s_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", s_readdata); end
    rst_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    logic wrv, rdv; logic [1:0] resp;
    logic [9:0] frame;
    frame = {1'b1, 8'h41, 1'b0};
    exp_q.push_back(8'h41);
    do_write(A_TX, 32'h4100_0000, 4'hF, 5'd1, 1'b0, wrv, rdv, resp);
    n_cmp++;
    if ({wrv, resp} !== {1'b1, 2'b00}) begin
      n_fail++; $display("FAIL single_wresp: got wrv=%b resp=%b want 1/00", wrv, resp);
    end
    @(negedge clk);
    n_cmp++;
    if (uart_all_done !== 1'b0) begin n_fail++; $display("FAIL single_done_fall: got %b want 0", uart_all_done); end
    for (int k = 0; k < 10; k++) begin
      int bad = 0;
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (uart_tx_o !== frame[k]) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
        n_fail++; $display("FAIL single_frame_bit%0d: got %0d wrong samples want line=%b", k, bad, frame[k]);
      end
    end
    n_cmp++;
    if (uart_all_done !== 1'b0) begin n_fail++; $display("FAIL single_done_stop: got %b want 0", uart_all_done); end
    @(negedge clk);
    n_cmp++;
    if (uart_all_done !== 1'b1) begin n_fail++; $display("FAIL single_done_rise: got %b want 1", uart_all_done); end
    drain_and_compare("single", 50);
  endtask

  task automatic test_back_to_back();
    int total, last, c;
    // One byte leaves the FIFO right away, so the 18th write is the first to stall.
    write_stream(18, 8'h30, 1'b1, total, last);
    n_cmp++;
    if (total != last) begin n_fail++; $display("FAIL b2b_early_stall: got %0d stall cycles before write 18 want 0", total - last); end
    n_cmp++;
    if (last == 0 || last >= 2000) begin n_fail++; $display("FAIL b2b_overflow_stall: got %0d want 1..1999", last); end
    drain_and_compare("b2b", 18 * 45 + 200);
    c = 0;
    while (uart_all_done !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    n_cmp++;
    if (uart_all_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", uart_all_done); end
  endtask

  task automatic test_status_read();
    int total, last, c;
    logic early, rdv; logic [31:0] data; logic [1:0] resp;
    write_stream(4, 8'hC1, 1'b1, total, last);
    do_read(A_ST, 5'd1, early, rdv, data, resp);
    n_cmp++;
    if ({early, rdv} !== 2'b01) begin n_fail++; $display("FAIL status_rdv: got early/late %b want 01", {early, rdv}); end
    n_cmp++;
    if (data !== 32'h0103_0000) begin n_fail++; $display("FAIL status_busy: got %h want 01030000", data); end
    do_read(A_OTH, 5'd1, early, rdv, data, resp);
    n_cmp++;
    if ({rdv, data, resp} !== {1'b1, 32'h0, 2'b00}) begin
      n_fail++; $display("FAIL other_read: got rdv=%b data=%h resp=%b want 1/0/00", rdv, data, resp);
    end
    drain_and_compare("status", 4 * 45 + 100);
    c = 0;
    while (uart_all_done !== 1'b1 && c < 20) begin @(negedge clk); c++; end
    do_read(A_ST, 5'd1, early, rdv, data, resp);
    n_cmp++;
    if (data !== 32'h0400_0000) begin n_fail++; $display("FAIL status_idle: got %h want 04000000", data); end
  endtask

  task automatic test_byteenable();
    logic wrv, rdv; logic [1:0] resp;
    int bad = 0;
    do_write(A_TX, 32'h5A00_0000, 4'h7, 5'd1, 1'b0, wrv, rdv, resp);
    n_cmp++;
    if ({wrv, resp} !== {1'b1, 2'b00}) begin n_fail++; $display("FAIL be_wresp: got %b/%b want 1/00", wrv, resp); end
    repeat (50) begin
      @(negedge clk);
      if (uart_all_done !== 1'b1 || uart_tx_o !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL be_discard: got %0d active cycles %0d bytes want 0/0", bad, rx_q.size());
    end
  endtask

  task automatic test_errors();
    logic wrv, rdv, early; logic [1:0] resp; logic [31:0] data;
    int bad = 0;
    do_write(A_TX, 32'h6600_0000, 4'hF, 5'd2, 1'b0, wrv, rdv, resp);
    n_cmp++;
    if ({wrv, resp} !== {1'b1, 2'b10}) begin n_fail++; $display("FAIL burst_wresp: got %b/%b want 1/10", wrv, resp); end
    repeat (20) begin
      @(negedge clk);
      if (uart_all_done !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin n_fail++; $display("FAIL burst_nopush: got %0d busy cycles want 0", bad); end
    do_read(A_ST, 5'd3, early, rdv, data, resp);
    n_cmp++;
    if ({rdv, resp} !== {1'b1, 2'b10}) begin n_fail++; $display("FAIL burst_rresp: got %b/%b want 1/10", rdv, resp); end
    do_write(A_OTH, 32'h0, 4'hF, 5'd1, 1'b1, wrv, rdv, resp);
    n_cmp++;
    if ({wrv, rdv, resp} !== {1'b1, 1'b0, 2'b10}) begin
      n_fail++; $display("FAIL rw_clash: got wrv=%b rdv=%b resp=%b want 1/0/10", wrv, rdv, resp);
    end
    do_write(32'h1234_0000, 32'h7700_0000, 4'hF, 5'd1, 1'b0, wrv, rdv, resp);
    n_cmp++;
    if (wrv !== 1'b0) begin n_fail++; $display("FAIL unselected: got wrv=%b want 0", wrv); end
  endtask

  task automatic test_reset_mid_frame();
    int total, last;
    int bad = 0;
    logic early, rdv; logic [31:0] data; logic [1:0] resp;
    write_stream(2, 8'h55, 1'b0, total, last);
    repeat (12) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({uart_tx_o, uart_all_done} !== 2'b11) begin
      n_fail++; $display("FAIL midrst_line: got tx/done %b want 11", {uart_tx_o, uart_all_done});
    end
    @(negedge clk);
    rst_i = 1'b0;
    do_read(A_ST, 5'd1, early, rdv, data, resp);
    n_cmp++;
    if (data !== 32'h0400_0000) begin n_fail++; $display("FAIL midrst_status: got %h want 04000000", data); end
    repeat (60) begin
      @(negedge clk);
      if (uart_tx_o !== 1'b1 || uart_all_done !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL midrst_flush: got %0d active cycles %0d bytes want 0/0", bad, rx_q.size());
    end
    rx_q.delete();
  endtask

  initial begin
    rst_i = 1'b1;
    bus_idle();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_status_read();
    test_byteenable();
    test_errors();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
